// File: rtl/add_subtract_pkg.sv
// Shared constants and types for the add/subtract seven-segment block.
package add_subtract_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef logic signed [4:0] result_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex value to active-high seven-segment pattern.
module seg7_hex_decoder
    import add_subtract_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_value)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/add_subtract_seg.sv
// Registered 3-bit add/subtract; magnitude shown as a hex digit, DP marks negative.
module add_subtract_seg
    import add_subtract_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       O,
    output logic [6:0] S,
    output logic       DP,
    output logic [4:0] res
);

    logic [4:0] w_a_ext;
    logic [4:0] w_b_ext;
    result_t    w_sum;
    logic       w_neg;
    logic [4:0] w_abs;
    logic [3:0] w_mag;
    logic [6:0] w_seg;

    logic [6:0] r_seg;
    logic       r_dp;
    result_t    r_res;

    always_comb begin
        w_a_ext = {2'b00, A};
        w_b_ext = {2'b00, B};
        w_sum   = (O == OP_SUB) ? result_t'(w_a_ext - w_b_ext) : result_t'(w_a_ext + w_b_ext);
        // A zero result has a clear sign bit, so negative zero cannot occur
        w_neg   = w_sum[4];
        w_abs   = w_neg ? (5'd0 - w_sum) : w_sum;
        w_mag   = w_abs[3:0];
    end

    seg7_hex_decoder u_dec (
        .i_value (w_mag),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b0;
            r_res <= '0;
        end else begin
            r_seg <= w_seg;
            r_dp  <= w_neg;
            r_res <= w_sum;
        end
    end

    assign S   = r_seg;
    assign DP  = r_dp;
    assign res = r_res;

endmodule

// File: tb/tb_add_subtract_seg.sv
// Directed and exhaustive checks of add_subtract_seg against hand values and a small model.
module tb_add_subtract_seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] A;
    logic [2:0] B;
    logic       O;
    logic [6:0] S;
    logic       DP;
    logic [4:0] res;

    int errors = 0;
    int checks = 0;
    logic [6:0] seg_tab [16];

    always #5 clk = ~clk;

    add_subtract_seg dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .O   (O),
        .S   (S),
        .DP  (DP),
        .res (res)
    );

    task automatic drive(input logic r, input logic [2:0] a, input logic [2:0] b,
                         input logic o);
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        O   = o;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] er, input logic [6:0] es,
                         input logic ed);
        checks++;
        assert (res === er) else begin
            errors++;
            $error("FAIL %s res got %b exp %b", tag, res, er);
        end
        checks++;
        assert (S === es) else begin
            errors++;
            $error("FAIL %s S got %b exp %b", tag, S, es);
        end
        checks++;
        assert (DP === ed) else begin
            errors++;
            $error("FAIL %s DP got %b exp %b", tag, DP, ed);
        end
    endtask

    task automatic model_check(input string tag, input logic [2:0] a, input logic [2:0] b,
                               input logic o);
        int rv;
        int m;
        rv = o ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        m  = (rv < 0) ? -rv : rv;
        check(tag, 5'(rv), seg_tab[4'(m)], rv < 0);
    endtask

    initial begin
        seg_tab[0]  = 7'b0111111; seg_tab[1]  = 7'b0000110;
        seg_tab[2]  = 7'b1011011; seg_tab[3]  = 7'b1001111;
        seg_tab[4]  = 7'b1100110; seg_tab[5]  = 7'b1101101;
        seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b0000111;
        seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1101111;
        seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b1111100;
        seg_tab[12] = 7'b0111001; seg_tab[13] = 7'b1011110;
        seg_tab[14] = 7'b1111001; seg_tab[15] = 7'b1110001;

        rst = 1'b1;
        A   = 3'd5;
        B   = 3'd3;
        O   = 1'b0;

        drive(1'b1, 3'd5, 3'd3, 1'b0);
        check("reset_1", 5'd0, 7'b0000000, 1'b0);
        drive(1'b1, 3'd5, 3'd3, 1'b0);
        check("reset_2", 5'd0, 7'b0000000, 1'b0);
        drive(1'b0, 3'd5, 3'd3, 1'b0);
        check("post_reset_5p3", 5'd8, 7'b1111111, 1'b0);

        drive(1'b0, 3'd3, 3'd4, 1'b0);
        check("3p4", 5'd7, 7'b0000111, 1'b0);
        drive(1'b0, 3'd3, 3'd4, 1'b1);
        check("3m4", 5'b11111, 7'b0000110, 1'b1);
        drive(1'b0, 3'd7, 3'd7, 1'b0);
        check("7p7", 5'd14, 7'b1111001, 1'b0);
        drive(1'b0, 3'd7, 3'd7, 1'b1);
        check("7m7_no_neg_zero", 5'd0, 7'b0111111, 1'b0);
        drive(1'b0, 3'd2, 3'd6, 1'b1);
        check("2m6", 5'b11100, 7'b1100110, 1'b1);
        drive(1'b0, 3'd0, 3'd7, 1'b1);
        check("0m7", 5'b11001, 7'b0000111, 1'b1);
        drive(1'b0, 3'd0, 3'd0, 1'b0);
        check("0p0", 5'd0, 7'b0111111, 1'b0);

        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            if (i == 64) begin
                drive(1'b1, v[6:4], v[3:1], v[0]);
                check("sweep_mid_reset", 5'd0, 7'b0000000, 1'b0);
            end
            drive(1'b0, v[6:4], v[3:1], v[0]);
            model_check($sformatf("sweep_a%0d_b%0d_o%0d", v[6:4], v[3:1], v[0]),
                        v[6:4], v[3:1], v[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_subtract_seg.md
Name: add_subtract_seg

Overview:
- Registered 3-bit unsigned adder/subtractor that drives a single seven-segment digit.
- Operand inputs A and B. Op select O: 0 = A+B, 1 = A−B.
- The display shows the result magnitude as a hex digit (0..E). DP lights to mark a negative result.
- Sits between board switches and one 7-seg digit; a two's-complement result bus is also exported for checking.

Parameters:
- none (widths fixed: operands 3 bits, result 5 bits signed, segments 7 bits)

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous active-high reset
- A  input  3  unsigned operand, 0..7
- B  input  3  unsigned operand, 0..7
- O  input  1  operation select: 0 add, 1 subtract (A−B)
- S  output  7  segment drive, active-high (1 = lit), S[0]=a, S[1]=b, S[2]=c, S[3]=d, S[4]=e, S[5]=f, S[6]=g
- DP  output  1  decimal point, active-high; 1 = result negative
- res  output  5  registered signed two's-complement result, range −7..+14

Behaviour:
- Reset: synchronous, active-high. On any clk edge with rst=1: S=7'b0000000 (blank), DP=0, res=0.
  - rst has priority over all inputs.
  - Reset asserted mid-stream discards the pending result.
- Arithmetic:
  - Zero-extend A and B to 5 bits.
  - O=0: r = A+B, range 0..14, never overflows 5 bits.
  - O=1: r = A−B, range −7..+7.
- Sign/magnitude:
  - neg = r[4].
  - mag = neg ? −r : r, 4 bits, range 0..14.
  - A zero result is never negative: A−B=0 gives DP=0 (no negative zero).
- Segment encoding of mag, active-high, listed as g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001
  - F=1110001 is defined in the decoder but unreachable.
- Latency: fully combinational compute, then one register stage.
  - Inputs sampled at rising edge N; S, DP and res reflect them after edge N, i.e. one-cycle latency.
  - Outputs hold until the next edge. No handshake; inputs are sampled every cycle.
- No state machine.
- Every reachable input combination (128) yields a defined output; no X on outputs after reset.

Decomposition:
- Package add_subtract_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - SEG_0..SEG_F 7-bit active-high segment constants.
  - SEG_BLANK=7'b0.
  - typedef for the 5-bit signed result.
- One sub-module, seg7_hex_decoder: purely combinational 4-bit value -> 7-bit segments.
- Top handles arithmetic, sign/magnitude and the output registers.

Test Plan:
- rst=1 for 2 cycles with A=5, B=3, O=0 -> S=0000000, DP=0, res=0 while rst is high; first edge after rst drops gives S=1111111 (8), DP=0, res=8.
- A=3, B=4, O=0 -> after one edge: res=7, S=0000111, DP=0.
- A=3, B=4, O=1 -> res=−1 (5'b11111), S=0000110 (1), DP=1.
- A=7, B=7, O=0 -> res=14, S=1111001 (E), DP=0; A=7, B=7, O=1 -> res=0, S=0111111, DP=0 (no negative zero).
- A=2, B=6, O=1 -> res=−4, S=1100110 (4), DP=1; A=0, B=7, O=1 -> res=−7, S=0000111, DP=1.
- Exhaustive sweep of all 128 {A,B,O} -> each output, compared one cycle later, matches the golden model; assert rst mid-sweep -> outputs blank on that edge.
